// File: rtl/tx_symbol_framer.sv
// Transmit-side 8-bit lane symbol framer: wraps packets in STP/END, nullifies
// underrun packets with EDB, fills gaps with IDLE and inserts SKP ordered sets.
module tx_symbol_framer #(
  parameter logic [7:0]  COM          = 8'hBC,
  parameter logic [7:0]  STP          = 8'hFB,
  parameter logic [7:0]  END          = 8'hFD,
  parameter logic [7:0]  EDB          = 8'hFE,
  parameter logic [7:0]  SKP          = 8'h1C,
  parameter logic [7:0]  IDLE         = 8'h7C,
  parameter int unsigned SKP_INTERVAL = 16,
  parameter int unsigned SKP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] tx_DataE,
  input  logic       tx_Valid,
  input  logic       tx_Last,
  output logic       tx_Ready,
  output logic [7:0] tx_DataS,
  output logic       tx_K,
  output logic       k285
);

  localparam int unsigned IW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_END, S_SKP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] skp_q, skp_d;
  logic [7:0]    data_q, data_d;
  logic          k_q, k_d;
  logic          k285_q;
  logic          expire;

  // An expiry on the current cycle counts as pending so the set is never late.
  assign expire = (ivl_q == IW'(SKP_INTERVAL - 1));

  always_comb begin
    state_d = state_q;
    ivl_d   = expire ? '0 : ivl_q + IW'(1);
    pend_d  = pend_q | expire;
    skp_d   = skp_q;
    data_d  = data_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q || expire) begin
          data_d  = COM;
          k_d     = 1'b1;
          pend_d  = 1'b0;
          skp_d   = '0;
          state_d = S_SKP;
        end else if (tx_Valid) begin
          data_d  = STP;
          k_d     = 1'b1;
          state_d = S_DATA;
        end else begin
          data_d  = IDLE;
          k_d     = 1'b1;
        end
      end
      S_DATA: begin
        if (tx_Valid) begin
          data_d = tx_DataE;
          k_d    = 1'b0;
          if (tx_Last) state_d = S_END;
        end else begin
          data_d  = EDB;
          k_d     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_END: begin
        data_d  = END;
        k_d     = 1'b1;
        state_d = S_IDLE;
      end
      S_SKP: begin
        data_d = SKP;
        k_d    = 1'b1;
        skp_d  = skp_q + CW'(1);
        if (skp_q == CW'(SKP_COUNT - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ivl_q   <= '0;
      pend_q  <= 1'b0;
      skp_q   <= '0;
      data_q  <= 8'h00;
      k_q     <= 1'b0;
      k285_q  <= 1'b0;
    end else if (enb) begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      pend_q  <= pend_d;
      skp_q   <= skp_d;
      data_q  <= data_d;
      k_q     <= k_d;
      k285_q  <= (data_d == COM);
    end
  end

  assign tx_Ready = enb & (state_q == S_DATA);
  assign tx_DataS = data_q;
  assign tx_K     = k_q;
  assign k285     = k285_q;

endmodule

// File: tb/tb_tx_symbol_framer.sv
// Randomized bench for tx_symbol_framer against a symbol-level reference model,
// with a directed idle/packet prefix pinned to literal symbol values.
module tb_tx_symbol_framer;

  localparam logic [7:0]  COM  = 8'hBC;
  localparam logic [7:0]  STP  = 8'hFB;
  localparam logic [7:0]  ENDS = 8'hFD;
  localparam logic [7:0]  EDB  = 8'hFE;
  localparam logic [7:0]  SKP  = 8'h1C;
  localparam logic [7:0]  IDL  = 8'h7C;
  localparam int unsigned SKP_INTERVAL = 16;
  localparam int unsigned SKP_COUNT    = 3;
  localparam int          N_ITER       = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [7:0] tx_DataE;
  logic       tx_Valid;
  logic       tx_Last;
  logic       tx_Ready;
  logic [7:0] tx_DataS;
  logic       tx_K;
  logic       k285;

  always #5 clk = ~clk;

  tx_symbol_framer #(
    .COM(COM), .STP(STP), .END(ENDS), .EDB(EDB), .SKP(SKP), .IDLE(IDL),
    .SKP_INTERVAL(SKP_INTERVAL), .SKP_COUNT(SKP_COUNT)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .tx_DataE(tx_DataE), .tx_Valid(tx_Valid), .tx_Last(tx_Last),
    .tx_Ready(tx_Ready), .tx_DataS(tx_DataS), .tx_K(tx_K), .k285(k285)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle gap, 1 inside packet, 2 END owed, 3 SKPs owed.
  int         n;
  int         mode;
  int         skp_left;
  bit         owed;
  logic [7:0] e_data;
  logic       e_k;
  logic [8:0] q[$];
  logic [7:0] lit[1:32];
  int         phase;
  bit         rst_done;

  task automatic model_reset();
    n = 0; mode = 0; skp_left = 0; owed = 1'b0; e_data = 8'h00; e_k = 1'b0;
  endtask

  task automatic push_pkt(input int len);
    for (int i = 0; i < len; i++)
      q.push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
  endtask

  task automatic drive(input int it);
    if (phase == 0 && n >= 34) begin
      push_pkt(40);
      phase = 1;
    end
    if (phase == 1 && q.size() == 0) phase = 2;
    case (phase)
      0: begin
        enb      = 1'b1;
        tx_Valid = (n >= 19) && (q.size() > 0);
      end
      1: begin
        enb      = !(it >= 60 && it < 63);
        tx_Valid = 1'b1;
      end
      default: begin
        enb = ($urandom_range(9) != 0);
        if (q.size() < 3) push_pkt(int'($urandom_range(6, 1)));
        tx_Valid = ($urandom_range(7) != 0);
      end
    endcase
    if (tx_Valid) begin
      tx_DataE = q[0][7:0];
      tx_Last  = q[0][8];
    end else begin
      tx_DataE = 8'($urandom);
      tx_Last  = 1'($urandom);
    end
  endtask

  // Symbol decision for one enabled edge, from the framing rules.
  task automatic model_step();
    n++;
    if (n % SKP_INTERVAL == 0) owed = 1'b1;
    case (mode)
      0: begin
        e_k = 1'b1;
        if (owed) begin
          e_data = COM; owed = 1'b0; skp_left = SKP_COUNT; mode = 3;
        end else if (tx_Valid) begin
          e_data = STP; mode = 1;
        end else begin
          e_data = IDL;
        end
      end
      1: begin
        if (tx_Valid) begin
          e_data = tx_DataE; e_k = 1'b0; q.delete(0);
          mode = tx_Last ? 2 : 1;
        end else begin
          e_data = EDB; e_k = 1'b1; mode = 0;
        end
      end
      2: begin
        e_data = ENDS; e_k = 1'b1; mode = 0;
      end
      default: begin
        e_data = SKP; e_k = 1'b1; skp_left--;
        if (skp_left == 0) mode = 0;
      end
    endcase
  endtask

  task automatic chk_reset_vals();
    chk("rst_data",  9'(tx_DataS), 9'h000);
    chk("rst_k",     9'(tx_K),     9'h000);
    chk("rst_k285",  9'(k285),     9'h000);
    chk("rst_ready", 9'(tx_Ready), 9'h000);
  endtask

  initial begin
    for (int i = 1; i <= 15; i++) lit[i] = IDL;
    lit[16] = COM;
    for (int i = 17; i <= 19; i++) lit[i] = SKP;
    lit[20] = STP; lit[21] = 8'h11; lit[22] = 8'h22; lit[23] = 8'h33; lit[24] = ENDS;
    for (int i = 25; i <= 31; i++) lit[i] = IDL;
    lit[32] = COM;

    rst = 1'b0; enb = 1'b1; tx_Valid = 1'b0; tx_Last = 1'b0; tx_DataE = 8'h00;
    phase = 0; rst_done = 1'b0;
    model_reset();
    q.push_back({1'b0, 8'h11});
    q.push_back({1'b0, 8'h22});
    q.push_back({1'b1, 8'h33});
    repeat (3) @(negedge clk);
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;

    for (int it = 0; it < N_ITER; it++) begin
      if (!rst_done && phase == 2 && it >= 1500 && mode == 1) begin
        rst_done = 1'b1;
        #2 rst = 1'b0;
        #1 chk_reset_vals();
        model_reset();
        tx_Valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        continue;
      end
      drive(it);
      #1;
      chk("data",  9'(tx_DataS), 9'(e_data));
      chk("k",     9'(tx_K),     9'(e_k));
      chk("k285",  9'(k285),     9'(e_data == COM));
      chk("ready", 9'(tx_Ready), 9'(enb && mode == 1));
      if (phase == 0 && n >= 1 && n <= 32) begin
        chk("lit_data", 9'(tx_DataS), 9'(lit[n]));
        chk("lit_k",    9'(tx_K),     9'((n < 21 || n > 23) ? 1'b1 : 1'b0));
      end
      @(posedge clk);
      if (enb) model_step();
      @(negedge clk);
    end

    if (!rst_done) chk("reset_mid_packet_reached", 9'(rst_done), 9'h001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
